// File: rtl/uart_rx_int.sv
// UART 8N1 receiver with a synchronised input line, mid-bit sampling and
// sticky receive, framing-error and overrun flags for the control unit.
module uart_rx_int #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SERIALDATAIN,
    input  logic       CLRRXINT,
    output logic [7:0] DATARX,
    output logic       RXINT,
    output logic       FRAMEERR,
    output logic       OVERRUN,
    output logic       RXBUSY
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   rxs;
    logic                   rxs_d;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic [2:0]             bit_idx;
    logic [2:0]             bit_nxt;
    logic [7:0]             shift;
    logic                   shift_en;
    logic                   done_ok;
    logic                   done_err;

    assign rxs    = sync_p0[SYNC_STAGES-1];
    assign RXBUSY = (state != IDLE);

    // Synchroniser chain plus one-cycle delay for falling-edge detection;
    // both reset to the idle-high level so reset never fakes a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= '1;
            rxs_d   <= 1'b1;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], SERIALDATAIN};
            rxs_d   <= rxs;
        end
    end

    // FSM state, clock counter and bit index registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
        end
    end

    // Next-state logic: counter timing, sample strobes and frame completion.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        bit_nxt   = bit_idx;
        shift_en  = 1'b0;
        done_ok   = 1'b0;
        done_err  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (rxs_d && !rxs) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (cnt == CNT_HALF_LAST) begin
                    cnt_nxt = '0;
                    if (rxs) begin
                        // Start bit gone by mid-bit: line glitch, not a frame.
                        state_nxt = IDLE;
                    end else begin
                        bit_nxt   = '0;
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (cnt == CNT_BIT_LAST) begin
                    cnt_nxt  = '0;
                    shift_en = 1'b1;
                    bit_nxt  = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt == CNT_BIT_LAST) begin
                    cnt_nxt = '0;
                    if (rxs) begin
                        done_ok   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        done_err  = 1'b1;
                        state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                // Hold off until the line is released so a long break
                // cannot be mistaken for a string of start bits.
                cnt_nxt = '0;
                if (rxs) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Receive shift register: LSB arrives first, so shift in from the top.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            shift <= {rxs, shift[7:1]};
        end
    end

    // Output byte and sticky flags; a completing byte beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            DATARX   <= 8'h00;
            RXINT    <= 1'b0;
            FRAMEERR <= 1'b0;
            OVERRUN  <= 1'b0;
        end else begin
            if (done_ok) begin
                DATARX   <= shift;
                RXINT    <= 1'b1;
                FRAMEERR <= 1'b0;
            end else if (CLRRXINT) begin
                RXINT <= 1'b0;
            end

            if (done_err) begin
                FRAMEERR <= 1'b1;
            end

            if (done_ok && RXINT && !CLRRXINT) begin
                OVERRUN <= 1'b1;
            end else if (CLRRXINT) begin
                OVERRUN <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_int.sv
// Testbench for uart_rx_int: drives serial frames and compares the outputs
// against a frame-level model of the receiver flags.
module tb_uart_rx_int;

    localparam int CPB    = 16;
    localparam int SYNC   = 2;
    localparam int HALF   = CPB / 2;
    localparam int DONE_K = SYNC + HALF + 9 * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic       SERIALDATAIN;
    logic       CLRRXINT;
    logic [7:0] DATARX;
    logic       RXINT;
    logic       FRAMEERR;
    logic       OVERRUN;
    logic       RXBUSY;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_data;
    logic       m_rxint;
    logic       m_fe;
    logic       m_ovr;

    uart_rx_int #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .SERIALDATAIN(SERIALDATAIN),
        .CLRRXINT    (CLRRXINT),
        .DATARX      (DATARX),
        .RXINT       (RXINT),
        .FRAMEERR    (FRAMEERR),
        .OVERRUN     (OVERRUN),
        .RXBUSY      (RXBUSY)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference model: flag effects of whole frames and clears.
    task automatic model_frame(input logic [7:0] b, input bit good, input bit clr);
        if (good) begin
            if (m_rxint && !clr) m_ovr = 1'b1;
            else if (clr)        m_ovr = 1'b0;
            m_data  = b;
            m_rxint = 1'b1;
            m_fe    = 1'b0;
        end else begin
            m_fe = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_data = 8'h00; m_rxint = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic hold(input logic v, input int n);
        SERIALDATAIN = v;
        repeat (n) @(negedge clk);
    endtask

    // stop_low = 0 sends a good stop bit, otherwise the line is held low that long.
    task automatic drive_frame(input logic [7:0] b, input int stop_low);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
        if (stop_low > 0) hold(1'b0, stop_low);
        else              hold(1'b1, CPB);
    endtask

    // Sends a frame, optionally pulsing CLRRXINT in the completion cycle, and
    // reports the cycle index (after the first posedge seeing the low line)
    // at which RXINT rose, or -1.
    task automatic send_frame(input logic [7:0] b, input int stop_low,
                              input bit clr_at_done, output int rise_k);
        int   rk;
        logic prev;
        rk   = -1;
        prev = RXINT;
        fork
            drive_frame(b, stop_low);
            begin
                for (int k = 0; k <= DONE_K + 1; k++) begin
                    if (clr_at_done && k == DONE_K) CLRRXINT = 1'b1;
                    @(negedge clk);
                    CLRRXINT = 1'b0;
                    if (RXINT && !prev && rk < 0) rk = k;
                    prev = RXINT;
                end
            end
        join
        rise_k = rk;
        model_frame(b, (stop_low == 0), clr_at_done);
    endtask

    task automatic test_reset();
        reset = 1'b1; SERIALDATAIN = 1'b1; CLRRXINT = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if ({DATARX, RXINT, FRAMEERR, OVERRUN, RXBUSY} !== 12'h000) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h",
                     {DATARX, RXINT, FRAMEERR, OVERRUN, RXBUSY}, 12'h000);
        end
    endtask

    task automatic test_basic();
        int rk;
        hold(1'b1, 4);
        send_frame(8'hA5, 0, 1'b0, rk);
        checks++;
        if (rk !== DONE_K) begin
            errors++;
            $display("FAIL rxint_latency: got %0d expected %0d", rk, DONE_K);
        end
        checks++;
        if ({DATARX, RXINT, FRAMEERR, OVERRUN} !== {m_data, m_rxint, m_fe, m_ovr}) begin
            errors++;
            $display("FAIL basic_a5: got %h expected %h",
                     {DATARX, RXINT, FRAMEERR, OVERRUN}, {m_data, m_rxint, m_fe, m_ovr});
        end
        CLRRXINT = 1'b1;
        @(negedge clk);
        CLRRXINT = 1'b0;
        m_rxint = 1'b0; m_ovr = 1'b0;
        checks++;
        if (RXINT !== 1'b0) begin
            errors++;
            $display("FAIL basic_clear: got RXINT=%b expected 0", RXINT);
        end
    endtask

    task automatic test_back_to_back();
        int rk;
        send_frame(8'h3C, 0, 1'b0, rk);
        send_frame(8'hC3, 0, 1'b0, rk);
        checks++;
        if ({DATARX, RXINT, FRAMEERR, OVERRUN} !== {8'hC3, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL b2b_overrun: got %h expected %h",
                     {DATARX, RXINT, FRAMEERR, OVERRUN}, {8'hC3, 1'b1, 1'b0, 1'b1});
        end
        CLRRXINT = 1'b1;
        @(negedge clk);
        CLRRXINT = 1'b0;
        m_rxint = 1'b0; m_ovr = 1'b0;
        checks++;
        if ({RXINT, OVERRUN} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_clear: got %b expected 00", {RXINT, OVERRUN});
        end
        hold(1'b1, 4);
    endtask

    task automatic test_frame_error();
        int rk;
        send_frame(8'h55, 40, 1'b0, rk);
        checks++;
        if ({DATARX, RXINT, FRAMEERR, RXBUSY} !== {m_data, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL frame_err: got %h expected %h",
                     {DATARX, RXINT, FRAMEERR, RXBUSY}, {m_data, 1'b0, 1'b1, 1'b1});
        end
        hold(1'b1, 1);
        checks++;
        if (RXBUSY !== 1'b1) begin
            errors++;
            $display("FAIL break_busy: got %b expected 1", RXBUSY);
        end
        hold(1'b1, 4);
        checks++;
        if (RXBUSY !== 1'b0) begin
            errors++;
            $display("FAIL break_release: got %b expected 0", RXBUSY);
        end
        send_frame(8'h0F, 0, 1'b0, rk);
        checks++;
        if ({DATARX, RXINT, FRAMEERR} !== {8'h0F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL frame_recover: got %h expected %h",
                     {DATARX, RXINT, FRAMEERR}, {8'h0F, 1'b1, 1'b0});
        end
        CLRRXINT = 1'b1;
        @(negedge clk);
        CLRRXINT = 1'b0;
        m_rxint = 1'b0; m_ovr = 1'b0;
        hold(1'b1, 4);
    endtask

    task automatic test_glitch();
        hold(1'b0, 4);
        checks++;
        if (RXBUSY !== 1'b1) begin
            errors++;
            $display("FAIL glitch_start: got RXBUSY=%b expected 1", RXBUSY);
        end
        hold(1'b1, 30);
        checks++;
        if ({DATARX, RXINT, FRAMEERR, RXBUSY} !== {m_data, m_rxint, m_fe, 1'b0}) begin
            errors++;
            $display("FAIL glitch_ignored: got %h expected %h",
                     {DATARX, RXINT, FRAMEERR, RXBUSY}, {m_data, m_rxint, m_fe, 1'b0});
        end
    endtask

    task automatic test_clr_collision();
        int rk;
        send_frame(8'($urandom), 0, 1'b0, rk);
        hold(1'b1, 3);
        send_frame(8'h81, 0, 1'b1, rk);
        checks++;
        if ({DATARX, RXINT, OVERRUN} !== {8'h81, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL clr_collision: got %h expected %h",
                     {DATARX, RXINT, OVERRUN}, {8'h81, 1'b1, 1'b0});
        end
        checks++;
        if ({DATARX, RXINT, FRAMEERR, OVERRUN} !== {m_data, m_rxint, m_fe, m_ovr}) begin
            errors++;
            $display("FAIL clr_collision_model: got %h expected %h",
                     {DATARX, RXINT, FRAMEERR, OVERRUN}, {m_data, m_rxint, m_fe, m_ovr});
        end
        hold(1'b1, 4);
    endtask

    task automatic test_reset_mid_frame();
        int rk;
        fork
            drive_frame(8'hFF, 0);
            begin
                repeat (60) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                model_reset();
                checks++;
                if ({DATARX, RXINT, FRAMEERR, OVERRUN, RXBUSY} !== 12'h000) begin
                    errors++;
                    $display("FAIL midframe_reset: got %h expected %h",
                             {DATARX, RXINT, FRAMEERR, OVERRUN, RXBUSY}, 12'h000);
                end
            end
        join
        hold(1'b1, 4);
        checks++;
        if ({DATARX, RXINT, FRAMEERR, OVERRUN, RXBUSY} !== 12'h000) begin
            errors++;
            $display("FAIL aborted_frame: got %h expected %h",
                     {DATARX, RXINT, FRAMEERR, OVERRUN, RXBUSY}, 12'h000);
        end
        send_frame(8'h12, 0, 1'b0, rk);
        checks++;
        if ({DATARX, RXINT, FRAMEERR, OVERRUN} !== {8'h12, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL post_reset_12: got %h expected %h",
                     {DATARX, RXINT, FRAMEERR, OVERRUN}, {8'h12, 1'b1, 1'b0, 1'b0});
        end
        hold(1'b1, 4);
    endtask

    task automatic test_random();
        int         rk;
        int         gap;
        int         stop_low;
        bit         bad;
        logic [7:0] b;
        for (int n = 0; n < 12; n++) begin
            b        = 8'($urandom);
            bad      = ($urandom_range(0, 3) == 0);
            stop_low = bad ? int'($urandom_range(16, 40)) : 0;
            gap      = bad ? int'($urandom_range(4, 10)) : int'($urandom_range(0, 6));
            send_frame(b, stop_low, 1'b0, rk);
            if (gap > 0) hold(1'b1, gap);
            checks++;
            if ({DATARX, RXINT, FRAMEERR, OVERRUN} !== {m_data, m_rxint, m_fe, m_ovr}) begin
                errors++;
                $display("FAIL random_frame %0d: got %h expected %h", n,
                         {DATARX, RXINT, FRAMEERR, OVERRUN}, {m_data, m_rxint, m_fe, m_ovr});
            end
            if ($urandom_range(0, 2) == 0) begin
                CLRRXINT = 1'b1;
                @(negedge clk);
                CLRRXINT = 1'b0;
                m_rxint = 1'b0; m_ovr = 1'b0;
                checks++;
                if ({RXINT, FRAMEERR, OVERRUN} !== {m_rxint, m_fe, m_ovr}) begin
                    errors++;
                    $display("FAIL random_clear %0d: got %b expected %b", n,
                             {RXINT, FRAMEERR, OVERRUN}, {m_rxint, m_fe, m_ovr});
                end
            end
        end
        hold(1'b1, 4);
    endtask

    initial begin
        reset = 1'b1; SERIALDATAIN = 1'b1; CLRRXINT = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_frame_error();
        test_glitch();
        test_clr_collision();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
